// File: rtl/inst_loader.sv
// inst_loader: boot-time loader that packs UART bytes big-endian into 32-bit words and writes them to instruction memory
//   clk, rst         clock and synchronous active-high reset
//   mode             core mode; 3'd1 selects LOAD
//   rx_data/valid    received byte and its valid flag; rx_ready accepts it (COLLECT only)
//   wr_en/addr/data  instruction-memory write port, one strobe per word
//   word_count       words written this load, terminator included
//   done, err        load finished / fault code (1 overflow, 2 timeout, 3 aborted)
module inst_loader #(
   parameter int          ADDR_W   = 14,
   parameter logic [31:0] END_WORD = 32'h0000_003F,
   parameter int          TIMEOUT  = 868000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        mode,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic [1:0]        err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_ERROR} state_t;
   state_t        r_state, w_next;
   logic [1:0]    r_idx;
   logic [TW-1:0] r_timer;
   logic          w_load, w_accept, w_timeout;
   assign w_load    = mode == 3'd1;
   assign rx_ready  = r_state == S_COLLECT;
   assign w_accept  = rx_valid && rx_ready;
   // the idle timer only runs inside a partial word; an accept in the same cycle wins
   assign w_timeout = !w_accept && r_idx != 2'd0 && r_timer == TW'(TIMEOUT - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = w_load ? S_COLLECT : S_IDLE;
         S_COLLECT: w_next = !w_load ? S_ERROR :
                             (w_accept && r_idx == 2'd3) ? S_WRITE :
                             w_timeout ? S_ERROR : S_COLLECT;
         S_WRITE:   w_next = (wr_data == END_WORD) ? S_DONE : (&wr_addr) ? S_ERROR : S_COLLECT;
         default:   w_next = w_load ? r_state : S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= 2'd0;
         r_timer    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         word_count <= '0;
         done       <= 1'b0;
         err        <= 2'd0;
      end else begin
         r_state <= w_next;
         wr_en   <= w_next == S_WRITE;
         case (r_state)
            S_IDLE: if (w_load) begin
               wr_addr    <= '0;
               word_count <= '0;
               r_idx      <= 2'd0;
               r_timer    <= '0;
               done       <= 1'b0;
               err        <= 2'd0;
            end
            S_COLLECT: begin
               // an abort discards the partial word, including a byte offered in the same cycle
               if (!w_load) err <= 2'd3;
               else if (w_accept) begin
                  wr_data <= {wr_data[23:0], rx_data};
                  r_idx   <= r_idx + 2'd1;
                  r_timer <= '0;
               end else if (w_timeout) err <= 2'd2;
               else if (r_idx != 2'd0) r_timer <= r_timer + TW'(1);
            end
            S_WRITE: begin
               word_count <= word_count + 1'b1;
               if (wr_data == END_WORD) done <= 1'b1;
               else if (&wr_addr) err <= 2'd1;
               else wr_addr <= wr_addr + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized self-checking bench for inst_loader against a byte-stream reference model
module tb_inst_loader;
   localparam int AW = 4;
   localparam int TO = 16;
   localparam logic [31:0] ENDW = 32'h0000_003F;
   logic          clk = 0, rst = 1, rx_valid = 0, rx_ready, wr_en, done;
   logic [2:0]    mode = 0;
   logic [7:0]    rx_data = 0;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic [AW:0]   word_count;
   logic [1:0]    err;
   int n_chk = 0, n_fail = 0;
   logic [AW+31:0] wlog[$];
   inst_loader #(.ADDR_W(AW), .END_WORD(ENDW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .word_count(word_count), .done(done), .err(err));
   always #5 clk = ~clk;
   // reference model: phase 0 idle, 1 collecting, 2 writing, 3 done, 4 error
   int ph = 0, m_nb = 0, m_idle = 0, m_nw = 0, m_wend = 0;
   logic [31:0] m_data = 0;
   logic        m_done = 0, started = 0;
   logic [1:0]  m_err = 0;
   always @(posedge clk) begin
      started = 1;
      if (rst) begin
         ph = 0; m_nb = 0; m_idle = 0; m_nw = 0; m_wend = 0; m_data = 0; m_done = 0; m_err = 0;
      end else if (ph == 0) begin
         if (mode == 1) begin ph = 1; m_nb = 0; m_idle = 0; m_nw = 0; m_wend = 0; m_done = 0; m_err = 0; end
      end else if (ph == 1) begin
         if (mode != 1) begin ph = 4; m_err = 3; end
         else if (rx_valid) begin
            m_data = (m_data << 8) | 32'(rx_data);
            m_idle = 0;
            m_nb = (m_nb + 1) % 4;
            if (m_nb == 0) ph = 2;
         end else if (m_nb != 0) begin
            m_idle++;
            if (m_idle == TO) begin ph = 4; m_err = 2; end
         end
      end else if (ph == 2) begin
         m_nw++;
         if (m_data == ENDW) begin ph = 3; m_done = 1; m_wend = 1; end
         else if (m_nw == 2 ** AW) begin ph = 4; m_err = 1; m_wend = 1; end
         else ph = 1;
      end else if (mode != 1) ph = 0;
   end
   always @(negedge clk) if (started) begin
      logic [AW-1:0] e_addr;
      e_addr = AW'(m_nw - m_wend);
      n_chk++;
      if (rx_ready !== (ph == 1) || wr_en !== (ph == 2) || wr_addr !== e_addr || wr_data !== m_data ||
          word_count !== (AW+1)'(m_nw) || done !== m_done || err !== m_err) begin
         n_fail++;
         $display("FAIL cycle t=%0t: got rdy=%b wen=%b addr=%0h data=%h cnt=%0d done=%b err=%0d, expected rdy=%b wen=%b addr=%0h data=%h cnt=%0d done=%b err=%0d",
                  $time, rx_ready, wr_en, wr_addr, wr_data, word_count, done, err,
                  ph == 1, ph == 2, e_addr, m_data, m_nw, m_done, m_err);
      end
      if (wr_en) wlog.push_back({wr_addr, wr_data});
   end
   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL %s: got %0h expected %0h", nm, a, e); end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send(input logic [7:0] b, input int gap);
      int n = 0;
      repeat (gap) @(negedge clk);
      while (!rx_ready && n < 40) begin @(negedge clk); n++; end
      if (!rx_ready) begin n_chk++; n_fail++; $display("FAIL send_ready: got 0 expected 1"); end
      else begin
         rx_valid = 1; rx_data = b;
         @(negedge clk);
         rx_valid = 0; rx_data = 8'($urandom);
      end
   endtask
   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 3; i >= 0; i--) send(w[8*i +: 8], $urandom_range(maxgap));
   endtask
   task automatic new_load();
      mode = 0; cyc(2); mode = 1; wlog.delete();
   endtask
   initial begin
      logic [31:0] words[16];
      cyc(3);
      chk("rst_addr", 64'(wr_addr), 0); chk("rst_cnt", 64'(word_count), 0);
      chk("rst_done", 64'(done), 0);    chk("rst_err", 64'(err), 0);
      rst = 0;
      new_load();
      send_word(32'h13, 0); send_word(ENDW, 0); cyc(3);
      chk("t1_nwr", wlog.size(), 2);
      chk("t1_w0", 64'(wlog[0]), {4'd0, 32'h13});
      chk("t1_w1", 64'(wlog[1]), {4'd1, 32'h3F});
      chk("t1_done", 64'(done), 1); chk("t1_cnt", 64'(word_count), 2); chk("t1_err", 64'(err), 0);
      mode = 0; cyc(2); chk("t1_done_hold", 64'(done), 1);
      new_load();
      for (int i = 0; i < 6; i++) words[i] = $urandom | 32'h8000_0000;
      words[6] = ENDW;
      for (int i = 0; i < 7; i++) send_word(words[i], 4);
      cyc(3);
      chk("t2_nwr", wlog.size(), 7);
      for (int i = 0; i < 7; i++) chk($sformatf("t2_w%0d", i), 64'(wlog[i]), {4'(i), words[i]});
      chk("t2_done", 64'(done), 1);
      new_load();
      for (int i = 0; i < 16; i++) begin words[i] = $urandom | 32'h8000_0000; send_word(words[i], 1); end
      cyc(3);
      chk("t3_nwr", wlog.size(), 16);
      for (int i = 0; i < 16; i++) chk($sformatf("t3_w%0d", i), 64'(wlog[i]), {4'(i), words[i]});
      chk("t3_err", 64'(err), 1); chk("t3_done", 64'(done), 0); chk("t3_cnt", 64'(word_count), 16);
      new_load();
      send(8'hAA, 0); send(8'hBB, 0); cyc(20);
      chk("t4_err", 64'(err), 2); chk("t4_nwr", wlog.size(), 0);
      new_load();
      send(8'h11, 0); send(8'h22, 1); send(8'h33, 2); mode = 0; cyc(2);
      chk("t5_err", 64'(err), 3); chk("t5_nwr", wlog.size(), 0);
      mode = 1; cyc(2); chk("t5_err_clr", 64'(err), 0);
      send_word(32'h1234_5678, 2); send_word(ENDW, 0); cyc(3);
      chk("t5_w0", 64'(wlog[0]), {4'd0, 32'h1234_5678}); chk("t5_cnt", 64'(word_count), 2);
      new_load();
      send(8'h55, 0); send(8'h66, 0); rst = 1; cyc(2);
      chk("t6_addr", 64'(wr_addr), 0); chk("t6_data", 64'(wr_data), 0); chk("t6_cnt", 64'(word_count), 0);
      chk("t6_done", 64'(done), 0);    chk("t6_err", 64'(err), 0);      chk("t6_wen", 64'(wr_en), 0);
      chk("t6_rdy", 64'(rx_ready), 0);
      rst = 0; wlog.delete();
      send_word(32'hAABB_CCDD, 3); send_word(ENDW, 0); cyc(3);
      chk("t6_nwr", wlog.size(), 2);
      chk("t6_w0", 64'(wlog[0]), {4'd0, 32'hAABB_CCDD}); chk("t6_done2", 64'(done), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
